clock_set_ctrl: RTL and testbench

Front-panel controller for the digital clock's time-keeping datapath (the hour, minute and second counters). It turns two debounced buttons into a set-mode state machine, and sequences the counters with a run enable and single-cycle increment/clear strobes. It also drives a field-select code and a blink enable to the display. It sits between the button debouncers and the second/minute/hour counter chain.

---
 rtl/clock_ctrl_pkg.sv | 38 +++
 rtl/btn_edge_det.sv | 21 ++
 rtl/clock_set_ctrl.sv | 143 ++++++++++++++
 tb/tb_clock_set_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_ctrl_pkg.sv
// rtl/clock_ctrl_pkg.sv - shared types, field codes and counter widths for the clock set controller
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        SET_SEC = 2'd3
    } set_state_t;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HR   = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;
    localparam logic [1:0] FIELD_SEC  = 2'd3;

    localparam int TIMEOUT_W = 6;
    localparam int REPEAT_W  = 4;
    localparam int BLINK_W   = 4;

    function automatic set_state_t next_mode(input set_state_t s);
        case (s)
            RUN:     return SET_HR;
            SET_HR:  return SET_MIN;
            SET_MIN: return SET_SEC;
            default: return RUN;
        endcase
    endfunction

    function automatic logic [1:0] state_field(input set_state_t s);
        case (s)
            SET_HR:  return FIELD_HR;
            SET_MIN: return FIELD_MIN;
            SET_SEC: return FIELD_SEC;
            default: return FIELD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/btn_edge_det.sv
// rtl/btn_edge_det.sv - press detector; a button held through reset is not a press
module btn_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic btn_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_prev <= 1'b1;
        end else begin
            btn_prev <= btn;
        end
    end

    assign press = btn & ~btn_prev;

endmodule

// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - front-panel set-mode controller for the hour/minute/second counters
// Optional auto-repeat of btn_inc: CLOCK_SET_AUTOREPEAT_EN
module clock_set_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int TIMEOUT_S   = 10,
    parameter int REPEAT_DLY  = 4,
    parameter int REPEAT_RATE = 1,
    parameter int BLINK_DIV   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_fast,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       run_en,
    output logic       inc_hr,
    output logic       inc_min,
    output logic       clr_sec,
    output logic [1:0] field,
    output logic       blink_on
);

    localparam logic [TIMEOUT_W-1:0] TO_LAST    = TIMEOUT_W'(TIMEOUT_S - 1);
    localparam logic [BLINK_W-1:0]   BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic mode_press;
    logic inc_press;

    btn_edge_det u_mode_edge (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_mode),
        .press (mode_press)
    );

    btn_edge_det u_inc_edge (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_inc),
        .press (inc_press)
    );

    set_state_t           state;
    set_state_t           state_nx;
    logic [TIMEOUT_W-1:0] to_cnt;
    logic [BLINK_W-1:0]   blink_cnt;
    logic                 in_set;
    logic                 timeout_hit;
    logic                 rpt_hit;
    logic                 strobe;

    assign in_set = (state != RUN);

    // A mode press landing on the final idle second still only returns to RUN.
    assign timeout_hit = in_set && tick_1hz && !btn_inc && (to_cnt == TO_LAST)
                         && (!btn_mode || mode_press);

`ifdef CLOCK_SET_AUTOREPEAT_EN
    localparam logic [REPEAT_W-1:0] RPT_DLY_C  = REPEAT_W'(REPEAT_DLY);
    localparam logic [REPEAT_W-1:0] RPT_RATE_C = REPEAT_W'(REPEAT_RATE);

    logic [REPEAT_W-1:0] rpt_cnt;
    logic                rpt_active;
    logic                rpt_live;

    assign rpt_live = btn_inc && !inc_press && !mode_press
                      && ((state == SET_HR) || (state == SET_MIN));
    assign rpt_hit  = rpt_live && tick_fast
                      && ((rpt_cnt + 1'b1) == (rpt_active ? RPT_RATE_C : RPT_DLY_C));

    always_ff @(posedge clk) begin
        if (rst || !rpt_live) begin
            rpt_cnt    <= '0;
            rpt_active <= 1'b0;
        end else if (tick_fast) begin
            if (rpt_hit) begin
                rpt_cnt    <= '0;
                rpt_active <= 1'b1;
            end else begin
                rpt_cnt <= rpt_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DLY[3:0], REPEAT_RATE[3:0]};
    assign rpt_hit = 1'b0;
`endif

    assign strobe = in_set && !mode_press && !timeout_hit && (inc_press || rpt_hit);

    always_comb begin
        state_nx = state;
        if (timeout_hit) begin
            state_nx = RUN;
        end else if (mode_press) begin
            state_nx = next_mode(state);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            run_en    <= 1'b1;
            inc_hr    <= 1'b0;
            inc_min   <= 1'b0;
            clr_sec   <= 1'b0;
            field     <= FIELD_NONE;
            blink_on  <= 1'b1;
            blink_cnt <= '0;
            to_cnt    <= '0;
        end else begin
            state   <= state_nx;
            run_en  <= (state_nx == RUN);
            field   <= state_field(state_nx);
            inc_hr  <= strobe && (state == SET_HR);
            inc_min <= strobe && (state == SET_MIN);
            clr_sec <= strobe && (state == SET_SEC);

            // Any activity, including a held btn_inc, restarts the idle count.
            if ((state_nx != state) || !in_set || mode_press || inc_press || btn_inc) begin
                to_cnt <= '0;
            end else if (tick_1hz && !btn_mode) begin
                to_cnt <= to_cnt + 1'b1;
            end

            if ((state_nx == RUN) || (state_nx != state) || strobe) begin
                blink_on  <= 1'b1;
                blink_cnt <= '0;
            end else if (tick_fast) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_on  <= ~blink_on;
                    blink_cnt <= '0;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - self-checking bench for clock_set_ctrl
module tb_clock_set_ctrl;

    localparam int T_S    = 10;
    localparam int R_DLY  = 4;
    localparam int R_RATE = 1;
    localparam int B_DIV  = 4;
`ifdef CLOCK_SET_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       tick_fast = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       run_en;
    logic       inc_hr;
    logic       inc_min;
    logic       clr_sec;
    logic [1:0] field;
    logic       blink_on;

    clock_set_ctrl #(
        .TIMEOUT_S   (T_S),
        .REPEAT_DLY  (R_DLY),
        .REPEAT_RATE (R_RATE),
        .BLINK_DIV   (B_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_1hz  (tick_1hz),
        .tick_fast (tick_fast),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .run_en    (run_en),
        .inc_hr    (inc_hr),
        .inc_min   (inc_min),
        .clr_sec   (clr_sec),
        .field     (field),
        .blink_on  (blink_on)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    int m_state = 0;
    int held    = 0;
    int idle    = 0;
    int bdiv    = 0;
    bit m_prev_mode = 1'b1;
    bit m_prev_inc  = 1'b1;
    bit m_blink = 1'b1;
    bit m_run   = 1'b1;
    bit m_hr    = 1'b0;
    bit m_min   = 1'b0;
    bit m_sec   = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: one evaluation of the front-panel rules per clock.
    always @(posedge clk) begin : model
        int  ns;
        int  k;
        bit  mp;
        bit  ip;
        bit  tout;
        bit  strobe;
        bit  hrmin;
        if (rst) begin
            m_state = 0; held = 0; idle = 0; bdiv = 0;
            m_prev_mode = 1'b1; m_prev_inc = 1'b1;
            m_blink = 1'b1; m_run = 1'b1;
            m_hr = 1'b0; m_min = 1'b0; m_sec = 1'b0;
        end else begin
            mp = btn_mode && !m_prev_mode;
            ip = btn_inc && !m_prev_inc;
            m_prev_mode = btn_mode;
            m_prev_inc  = btn_inc;
            hrmin = (m_state == 1) || (m_state == 2);
            tout = (m_state != 0) && tick_1hz && !btn_inc && (idle == T_S - 1)
                   && (!btn_mode || mp);
            ns = m_state;
            strobe = 1'b0;
            if (tout) begin
                ns = 0;
            end else if (mp) begin
                ns = (m_state + 1) % 4;
            end else if ((m_state != 0) && ip) begin
                strobe = 1'b1;
            end else if (AR && hrmin && btn_inc && tick_fast) begin
                k = held + 1;
                if (k == R_DLY || (k > R_DLY && ((k - R_DLY) % R_RATE) == 0))
                    strobe = 1'b1;
            end
            if (hrmin && ns == m_state && btn_inc && !ip) begin
                if (tick_fast) held++;
            end else begin
                held = 0;
            end
            if (ns != m_state || m_state == 0 || mp || ip || btn_inc) idle = 0;
            else if (tick_1hz && !btn_mode) idle++;
            if (ns == 0 || ns != m_state || strobe) begin
                m_blink = 1'b1;
                bdiv = 0;
            end else if (tick_fast) begin
                bdiv++;
                if (bdiv == B_DIV) begin
                    m_blink = !m_blink;
                    bdiv = 0;
                end
            end
            m_hr  = strobe && (m_state == 1);
            m_min = strobe && (m_state == 2);
            m_sec = strobe && (m_state == 3);
            m_state = ns;
            m_run = (ns == 0);
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("run_en",   8'(run_en),   8'(m_run));
            chk("field",    8'(field),    8'(m_state));
            chk("blink_on", 8'(blink_on), 8'(m_blink));
            chk("inc_hr",   8'(inc_hr),   8'(m_hr));
            chk("inc_min",  8'(inc_min),  8'(m_min));
            chk("clr_sec",  8'(clr_sec),  8'(m_sec));
        end
    end

    task automatic step(input logic m, input logic i, input logic t1, input logic tf);
        btn_mode  = m;
        btn_inc   = i;
        tick_1hz  = t1;
        tick_fast = tf;
        @(negedge clk);
    endtask

    task automatic mode_tap();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int pulses;
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_en = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset_run_en", 8'(run_en), 8'd1);
        chk("reset_blink",  8'(blink_on), 8'd1);

        // Mode held through reset release must not count as a press.
        rst = 1'b0;
        for (int c = 0; c < 5; c++) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("held_mode_field", 8'(field), 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("first_press_field", 8'(field), 8'd1);
        chk("first_press_run_en", 8'(run_en), 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("seq_field_2", 8'(field), 8'd2);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("seq_field_3", 8'(field), 8'd3);
        chk("seq_run_en_3", 8'(run_en), 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("seq_field_0", 8'(field), 8'd0);
        chk("seq_run_en_0", 8'(run_en), 8'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Mode and inc together in SET_MIN: mode wins.
        mode_tap();
        mode_tap();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("mode_wins_field", 8'(field), 8'd3);
        chk("mode_wins_no_inc", 8'(inc_min), 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        mode_tap();

        // Hold btn_inc in SET_HR across 10 tick_fast.
        mode_tap();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("inc_press_pulse", 8'(inc_hr), 8'd1);
        pulses = 1;
        for (int t = 0; t < 10; t++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1);
            if (inc_hr === 1'b1) pulses++;
            step(1'b0, 1'b1, 1'b0, 1'b0);
            if (inc_hr === 1'b1) pulses++;
        end
        chk("repeat_pulse_count", 8'(pulses), AR ? 8'd8 : 8'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Timeout in SET_SEC after 10 idle seconds.
        mode_tap();
        mode_tap();
        for (int t = 0; t < 9; t++) step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("timeout_not_yet", 8'(field), 8'd3);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("timeout_field", 8'(field), 8'd0);
        chk("timeout_run_en", 8'(run_en), 8'd1);

        // Inc press on the 9th second restarts the idle count.
        mode_tap();
        mode_tap();
        mode_tap();
        for (int t = 0; t < 8; t++) step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("tick9_clr_sec", 8'(clr_sec), 8'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int t = 10; t <= 18; t++) step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("tick18_still_set", 8'(field), 8'd3);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("tick19_timeout", 8'(field), 8'd0);

        // Mode press on the timeout second goes to RUN only.
        mode_tap();
        for (int t = 0; t < 9; t++) step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("mode_on_timeout_field", 8'(field), 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-repeat in SET_MIN.
        mode_tap();
        mode_tap();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int t = 0; t < 6; t++) step(1'b0, 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("rst_run_en", 8'(run_en), 8'd1);
        chk("rst_field", 8'(field), 8'd0);
        chk("rst_blink", 8'(blink_on), 8'd1);
        chk("rst_strobes", 8'({inc_hr, inc_min, clr_sec}), 8'd0);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Randomised traffic against the model.
        for (int c = 0; c < 6000; c++) begin
            logic m;
            logic i;
            m = btn_mode;
            i = btn_inc;
            if (m) m = ($urandom_range(0, 2) != 0);
            else   m = ($urandom_range(0, 59) == 0);
            if (i) i = ($urandom_range(0, 24) != 0);
            else   i = ($urandom_range(0, 59) == 0);
            rst = ($urandom_range(0, 799) == 0);
            step(m, i, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
        end
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
